muldiv_seq: RTL



---
 rtl/muldiv_seq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide sequencer feeding the HI/LO registers.
// Runs a 32-step shift-add or restoring-divide sequence on magnitudes, then sign-corrects.
module muldiv_seq #(
    parameter int STEPS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        hi_lo_write,
    output logic        div_zero,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int CW = $clog2(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t        state;
    logic          op_r;
    logic          res_neg;
    logic          dvd_neg;
    logic [31:0]   mag_a;
    logic [31:0]   mag_b;
    logic [63:0]   acc;
    logic [CW-1:0] cnt;

    logic [31:0]   abs_a;
    logic [31:0]   abs_b;
    logic [32:0]   mul_sum;
    logic [32:0]   div_trial;
    logic [63:0]   acc_next;
    logic [63:0]   fixed;

    // 0x80000000 maps to itself, which is the correct magnitude when read unsigned
    assign abs_a = a[31] ? (~a + 32'd1) : a;
    assign abs_b = b[31] ? (~b + 32'd1) : b;

    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, mag_a};
        div_trial = acc[63:31] - {1'b0, mag_b};
        acc_next  = acc;
        fixed     = acc;
        if (!op_r) begin
            acc_next = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};
            fixed    = res_neg ? (~acc + 64'd1) : acc;
        end else begin
            // acc holds {rem, quo}; trial subtraction uses the remainder after the left shift
            acc_next = div_trial[32] ? {acc[62:0], 1'b0}
                                     : {div_trial[31:0], acc[30:0], 1'b1};
            fixed    = {dvd_neg ? (~acc[63:32] + 32'd1) : acc[63:32],
                        res_neg ? (~acc[31:0] + 32'd1) : acc[31:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op_r        <= 1'b0;
            res_neg     <= 1'b0;
            dvd_neg     <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            acc         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi_lo_write <= 1'b0;
            div_zero    <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (op && (b == 32'd0)) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            state    <= DONE;
                        end else begin
                            op_r    <= op;
                            mag_a   <= abs_a;
                            mag_b   <= abs_b;
                            res_neg <= a[31] ^ b[31];
                            dvd_neg <= a[31];
                            // low half seeds the multiplier (MULT) or the dividend (DIV)
                            acc     <= op ? {32'd0, abs_a} : {32'd0, abs_b};
                            cnt     <= '0;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (cnt == LAST) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    hi_out      <= fixed[63:32];
                    lo_out      <= fixed[31:0];
                    done        <= 1'b1;
                    hi_lo_write <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done        <= 1'b0;
                    hi_lo_write <= 1'b0;
                    div_zero    <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
